// File: rtl/present_inv_sbox_keyadd_serial.sv
// PRESENT inverse S-box + key-add datapath, nibble-serial: out = S^-1(in ^ key) per nibble.
// Latency: NIBBLES+1 clocks from input accept to io_out_valid; throughput one word per NIBBLES+2 cycles.
// Backpressure: single word in flight; io_in_ready low in RUN/DONE, DONE holds result until io_out_ready.
// Optional feature macro: FAULT_DETECT_EN (duplicated inverse S-box with sticky io_fault flag).
module present_inv_sbox_keyadd_serial #(
  parameter int NIBBLES = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [4*NIBBLES-1:0]   io_in_data,
  input  logic [4*NIBBLES-1:0]   io_in_key,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [4*NIBBLES-1:0]   io_out_data
`ifdef FAULT_DETECT_EN
  ,
  output logic                   io_fault
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_data;
  logic [W-1:0]    r_key;
  logic [W-1:0]    r_out;
  logic            r_live;

  logic            w_accept;
  logic            w_last;
  logic [3:0]      w_data_nib;
  logic [3:0]      w_key_nib;
  logic [3:0]      w_xor_main;
  logic [3:0]      w_sbox_main;
  logic [3:0]      w_wr_nib;

  // PRESENT inverse S-box lookup
  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'hE;
      4'h2: y = 4'hF;
      4'h3: y = 4'h8;
      4'h4: y = 4'hC;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hD;
      4'h8: y = 4'hB;
      4'h9: y = 4'h4;
      4'hA: y = 4'h6;
      4'hB: y = 4'h3;
      4'hC: y = 4'h0;
      4'hD: y = 4'h7;
      4'hE: y = 4'h9;
      default: y = 4'hA;
    endcase
    return y;
  endfunction

  assign w_accept = io_in_valid && io_in_ready;
  assign w_last   = (r_cnt == LAST_CNT);

  // Select the operand nibbles addressed by the serial counter
  always_comb begin
    w_data_nib = '0;
    w_key_nib  = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_cnt == CW'(i)) begin
        w_data_nib = r_data[4*i +: 4];
        w_key_nib  = r_key[4*i +: 4];
      end
    end
  end

  assign w_xor_main  = w_data_nib ^ w_key_nib;
  assign w_sbox_main = inv_sbox(w_xor_main);

`ifdef FAULT_DETECT_EN
  logic [3:0] w_xor_dup;
  logic [3:0] w_sbox_dup;
  logic       w_mismatch;
  logic       r_fault;

  // Duplicate path recomputes the key-add from the latched operands so a
  // glitch in either XOR or either S-box shows up as a disagreement.
  assign w_xor_dup  = w_data_nib ^ w_key_nib;
  assign w_sbox_dup = inv_sbox(w_xor_dup);
  assign w_mismatch = (r_state == S_RUN) && (w_sbox_main != w_sbox_dup);
  assign w_wr_nib   = w_mismatch ? 4'h0 : w_sbox_main;

  // Sticky fault flag, cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fault <= 1'b0;
    end else if (w_mismatch) begin
      r_fault <= 1'b1;
    end
  end

  assign io_fault = r_fault;
`else
  assign w_wr_nib = w_sbox_main;
`endif

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)     w_state_nxt = S_RUN;
      S_RUN:   if (w_last)       w_state_nxt = S_DONE;
      S_DONE:  if (io_out_ready) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs; ready is held off until the first clock after reset release
  always_comb begin
    io_in_ready  = r_live && (r_state == S_IDLE);
    io_out_valid = (r_state == S_DONE);
    io_out_data  = r_out;
  end

  // Marks that at least one clock edge has passed since reset was released
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // Operand capture on accept, serial nibble write-back and counter in RUN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_data <= '0;
      r_key  <= '0;
      r_out  <= '0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_data <= io_in_data;
        r_key  <= io_in_key;
        r_cnt  <= '0;
      end else if (r_state == S_RUN) begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (r_cnt == CW'(i)) begin
            r_out[4*i +: 4] <= w_wr_nib;
          end
        end
        if (!w_last) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_present_inv_sbox_keyadd_serial.sv
module tb_present_inv_sbox_keyadd_serial;

  localparam int N = 16;
  localparam int W = 4 * N;

  logic          clock;
  logic          reset;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [W-1:0]  io_in_data;
  logic [W-1:0]  io_in_key;
  logic          io_out_valid;
  logic          io_out_ready;
  logic [W-1:0]  io_out_data;
`ifdef FAULT_DETECT_EN
  logic          io_fault;
`endif

  present_inv_sbox_keyadd_serial #(.NIBBLES(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_data   (io_in_data),
    .io_in_key    (io_in_key),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_data  (io_out_data)
`ifdef FAULT_DETECT_EN
    ,
    .io_fault     (io_fault)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic hold = 1'b1;
  logic prev_vld = 1'b0;

  logic [W-1:0] exp_q[$];
  int           acc_q[$];

  // Forward PRESENT S-box; the inverse is derived by table inversion
  logic [3:0] fwd_tbl [16];
  logic [3:0] inv_tbl [16];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input logic [W-1:0] k);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[4*i +: 4] = inv_tbl[d[4*i +: 4] ^ k[4*i +: 4]];
    return r;
  endfunction

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] k, input logic [W-1:0] e);
    int t;
    t = 0;
    io_in_valid = 1'b1;
    io_in_data  = d;
    io_in_key   = k;
    while (!io_in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!io_in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: ready stayed 0 want 1");
      io_in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      @(negedge clock);
      io_in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d results pending want 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  // Output acceptance pattern: random stalls unless forced low
  initial begin
    io_out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1 io_out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency at valid rise, data compare at each output handshake
  always @(negedge clock) begin
    if (!reset) begin
      prev_vld <= 1'b0;
    end else begin
      prev_vld <= io_out_valid;
      if (io_out_valid && !prev_vld) begin
        if (acc_q.size() == 0) check("latency_no_pending", W'(1), W'(0));
        else check("latency", W'(cyc - acc_q[0]), W'(N + 1));
      end
      if (io_out_valid && io_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", io_out_data, W'(0));
        end else begin
          check("out_data", io_out_data, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] k;
    logic [W-1:0] e;
    logic [W-1:0] snap;
    logic [3:0]   kn;
    int t;

    fwd_tbl = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    for (int x = 0; x < 16; x++) inv_tbl[fwd_tbl[x]] = 4'(x);

    reset = 1'b0;
    io_in_valid = 1'b0;
    io_in_data = '0;
    io_in_key = '0;
    #12;
    check("rst_in_ready", W'(io_in_ready), W'(0));
    check("rst_out_valid", W'(io_out_valid), W'(0));
    check("rst_out_data", io_out_data, W'(0));
`ifdef FAULT_DETECT_EN
    check("rst_fault", W'(io_fault), W'(0));
`endif
    @(negedge clock);
    reset = 1'b1;
    check("ready_before_edge", W'(io_in_ready), W'(0));
    @(negedge clock);
    check("ready_after_release", W'(io_in_ready), W'(1));
    hold = 1'b0;

    // Directed vectors
    send('0, '0, 64'h5555555555555555);
    send(64'hFEDCBA9876543210, '0, 64'hA970364BD21C8FE5);
    send('0, 64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA);

    // Round trip: encrypt-side S(x)^k fed back with the same k yields x
    for (int x = 0; x < 16; x++) begin
      kn = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        d[4*i +: 4] = fwd_tbl[x] ^ kn;
        k[4*i +: 4] = kn;
        e[4*i +: 4] = 4'(x);
      end
      send(d, k, e);
    end

    // Random words with random gaps
    for (int n = 0; n < 20; n++) begin
      d = {$urandom, $urandom};
      k = {$urandom, $urandom};
      send(d, k, ref_model(d, k));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    drain();

    // Backpressure: hold result in DONE for 20 cycles
    hold = 1'b1;
    @(negedge clock);
    d = {$urandom, $urandom};
    k = {$urandom, $urandom};
    send(d, k, ref_model(d, k));
    t = 0;
    while (!io_out_valid && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("stall_valid_seen", W'(io_out_valid), W'(1));
    snap = io_out_data;
    check("stall_snapshot", snap, ref_model(d, k));
    d = {$urandom, $urandom};
    k = {$urandom, $urandom};
    io_in_valid = 1'b1;
    io_in_data = d;
    io_in_key = k;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      check("stall_valid", W'(io_out_valid), W'(1));
      check("stall_data", io_out_data, snap);
      check("stall_in_ready", W'(io_in_ready), W'(0));
    end
    hold = 1'b0;
    send(d, k, ref_model(d, k));
    drain();

    // Reset in the middle of RUN at nibble 7
    d = {$urandom, $urandom};
    k = {$urandom, $urandom};
    send(d, k, ref_model(d, k));
    repeat (7) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", W'(io_out_valid), W'(0));
    check("midrst_in_ready", W'(io_in_ready), W'(0));
    check("midrst_out_data", io_out_data, W'(0));
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_back());
      void'(acc_q.pop_back());
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    d = {$urandom, $urandom};
    k = {$urandom, $urandom};
    send(d, k, ref_model(d, k));
    drain();

`ifdef FAULT_DETECT_EN
    // Disturb the duplicate S-box at nibble 3
    d = {$urandom, $urandom};
    k = {$urandom, $urandom};
    e = ref_model(d, k);
    e[15:12] = 4'h0;
    send(d, k, e);
    repeat (3) @(negedge clock);
    force dut.w_sbox_dup = ~dut.w_sbox_main;
    @(negedge clock);
    release dut.w_sbox_dup;
    check("fault_set", W'(io_fault), W'(1));
    drain();
    check("fault_sticky", W'(io_fault), W'(1));
    @(negedge clock);
    reset = 1'b0;
    #1 check("fault_cleared", W'(io_fault), W'(0));
    @(negedge clock);
    reset = 1'b1;
`endif

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
